// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with prescaler, wrap/saturate/one-shot modes, sync load/clear.
// Latency: count, tc, ovf and running are registered (1 edge); cmp_match is combinational from count.
// Backpressure: none; en gates the prescaler and one-shot completion stops stepping until clr/load.
//
// Ports:
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   clr, load        : synchronous clear (highest priority) and load of load_val (clipped to MAX_VAL)
//   en, presc        : count enable; one step per presc+1 enabled cycles
//   dir, mode        : 1 = up / 0 = down; 00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   cmp_val          : compare value for cmp_match
//   count, tc, ovf   : current count, terminal-count pulse, sticky boundary flag
//   cmp_match        : count == cmp_val
//   running          : low once a one-shot has reached its boundary
module updown_mod_counter #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned MAX_VAL = (1 << WIDTH) - 1,
   parameter int unsigned PRESC_W = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clr,
   input  logic               en,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_val,
   input  logic               dir,
   input  logic [1:0]         mode,
   input  logic [PRESC_W-1:0] presc,
   input  logic [WIDTH-1:0]   cmp_val,
   output logic [WIDTH-1:0]   count,
   output logic               tc,
   output logic               cmp_match,
   output logic               ovf,
   output logic               running
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

   localparam logic [1:0] MODE_SAT     = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;

   logic [WIDTH-1:0]   count_q, count_d;
   logic [PRESC_W-1:0] pcnt_q, pcnt_d;
   logic               tc_q, tc_d;
   logic               ovf_q, ovf_d;
   logic               running_q, running_d;

   logic [WIDTH-1:0]   load_clip;
   logic               step;
   logic               at_bound;

   // When the range covers the full word no value can exceed MAX_VAL, so the
   // clip comparison would be constant; skip it in that case.
   generate
      if (MAX_VAL == (1 << WIDTH) - 1) begin : g_full_range
         assign load_clip = load_val;
      end else begin : g_clip
         assign load_clip = (load_val > MAX_V) ? MAX_V : load_val;
      end
   endgenerate

   assign at_bound = dir ? (count_q == MAX_V) : (count_q == '0);

   always_comb begin
      count_d   = count_q;
      pcnt_d    = pcnt_q;
      tc_d      = 1'b0;
      ovf_d     = ovf_q;
      running_d = running_q;
      step      = 1'b0;

      if (clr) begin
         count_d   = '0;
         pcnt_d    = '0;
         ovf_d     = 1'b0;
         running_d = 1'b1;
      end else if (load) begin
         count_d   = load_clip;
         pcnt_d    = '0;
         running_d = 1'b1;
      end else if (en && running_q) begin
         // >= rather than == so that lowering presc mid-run fires immediately
         // instead of waiting for pcnt to wrap around.
         if (pcnt_q >= presc) begin
            pcnt_d = '0;
            step   = 1'b1;
         end else begin
            pcnt_d = pcnt_q + 1'b1;
         end
      end

      if (step) begin
         if (at_bound) begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
            case (mode)
               MODE_SAT:     count_d = count_q;
               MODE_ONESHOT: running_d = 1'b0;
               default:      count_d = dir ? '0 : MAX_V;
            endcase
         end else begin
            count_d = dir ? (count_q + 1'b1) : (count_q - 1'b1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q   <= '0;
         pcnt_q    <= '0;
         tc_q      <= 1'b0;
         ovf_q     <= 1'b0;
         running_q <= 1'b1;
      end else begin
         count_q   <= count_d;
         pcnt_q    <= pcnt_d;
         tc_q      <= tc_d;
         ovf_q     <= ovf_d;
         running_q <= running_d;
      end
   end

   assign count     = count_q;
   assign tc        = tc_q;
   assign ovf       = ovf_q;
   assign running   = running_q;
   assign cmp_match = (count_q == cmp_val);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter with WIDTH=4, MAX_VAL=9.
// Expected outputs are queued as stimulus is driven and compared after each edge.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that point.
module tb_updown_mod_counter;

   localparam int W  = 4;
   localparam int MV = 9;
   localparam int PW = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          clr;
   logic          en;
   logic          load;
   logic [W-1:0]  load_val;
   logic          dir;
   logic [1:0]    mode;
   logic [PW-1:0] presc;
   logic [W-1:0]  cmp_val;
   logic [W-1:0]  count;
   logic          tc;
   logic          cmp_match;
   logic          ovf;
   logic          running;

   typedef struct packed {
      logic [3:0] cnt;
      logic       tc;
      logic       ovf;
      logic       run;
      logic       cm;
   } obs_t;

   obs_t sb[$];
   int   errors = 0;
   int   checks = 0;

   updown_mod_counter #(.WIDTH(W), .MAX_VAL(MV), .PRESC_W(PW)) dut (
      .clock     (clock),
      .reset     (reset),
      .clr       (clr),
      .en        (en),
      .load      (load),
      .load_val  (load_val),
      .dir       (dir),
      .mode      (mode),
      .presc     (presc),
      .cmp_val   (cmp_val),
      .count     (count),
      .tc        (tc),
      .cmp_match (cmp_match),
      .ovf       (ovf),
      .running   (running)
   );

   always #5 clock = ~clock;

   function automatic obs_t mk(input int c, input bit t, input bit o, input bit r, input bit m);
      obs_t e;
      e.cnt = 4'(c);
      e.tc  = t;
      e.ovf = o;
      e.run = r;
      e.cm  = m;
      return e;
   endfunction

   function automatic obs_t sample();
      obs_t s;
      s.cnt = count;
      s.tc  = tc;
      s.ovf = ovf;
      s.run = running;
      s.cm  = cmp_match;
      return s;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      obs_t e, got;
      reset = 1'b1; clr = 1'b0; en = 1'b0; load = 1'b0; load_val = '0;
      dir = 1'b1; mode = 2'b00; presc = '0; cmp_val = 4'd0;
      #2;
      sb.push_back(mk(0, 0, 0, 1, 1));
      e = sb.pop_front(); got = sample(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset_state: got %b required %b", got, e); end
      cmp_val = 4'd3;
      #1;
      sb.push_back(mk(0, 0, 0, 1, 0));
      e = sb.pop_front(); got = sample(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset_cmp: got %b required %b", got, e); end
      en = 1'b1;
      sb.push_back(mk(0, 0, 0, 1, 0));
      tick();
      e = sb.pop_front(); got = sample(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset_hold: got %b required %b", got, e); end
      reset = 1'b0; en = 1'b0; cmp_val = 4'd15;
   endtask

   task automatic test_wrap_up();
      obs_t e, got;
      dir = 1'b1; mode = 2'b00; presc = '0; en = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         sb.push_back(mk(i % 10, i == 10, i >= 10, 1, 0));
         tick();
         e = sb.pop_front(); got = sample(); checks++;
         if (got !== e) begin errors++; $display("FAIL wrap_up step %0d: got %b required %b", i, got, e); end
      end
   endtask

   task automatic test_wrap_down();
      obs_t e, got;
      clr = 1'b1;
      sb.push_back(mk(0, 0, 0, 1, 0));
      tick();
      e = sb.pop_front(); got = sample(); checks++;
      if (got !== e) begin errors++; $display("FAIL wrap_down_clr: got %b required %b", got, e); end
      clr = 1'b0; dir = 1'b0; en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sb.push_back(mk(9 - i, i == 0, 1, 1, 0));
         tick();
         e = sb.pop_front(); got = sample(); checks++;
         if (got !== e) begin errors++; $display("FAIL wrap_down step %0d: got %b required %b", i, got, e); end
      end
   endtask

   task automatic test_saturate();
      obs_t e, got;
      obs_t exp_tab[6];
      clr = 1'b1; en = 1'b0;
      tick();
      clr = 1'b0;
      exp_tab = '{mk(8, 0, 0, 1, 0), mk(9, 0, 0, 1, 0), mk(9, 1, 1, 1, 0),
                  mk(9, 1, 1, 1, 0), mk(9, 1, 1, 1, 0), mk(0, 0, 0, 1, 0)};
      mode = 2'b01; dir = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd8;
      for (int i = 0; i < 6; i++) begin
         load = (i == 0);
         clr  = (i == 5);
         sb.push_back(exp_tab[i]);
         tick();
         e = sb.pop_front(); got = sample(); checks++;
         if (got !== e) begin errors++; $display("FAIL saturate step %0d: got %b required %b", i, got, e); end
      end
      clr = 1'b0;
   endtask

   task automatic test_oneshot();
      obs_t e, got;
      obs_t exp_tab[8];
      exp_tab = '{mk(7, 0, 0, 1, 0), mk(8, 0, 0, 1, 0), mk(9, 0, 0, 1, 0), mk(9, 1, 1, 0, 0),
                  mk(9, 0, 1, 0, 0), mk(9, 0, 1, 0, 0), mk(2, 0, 1, 1, 0), mk(3, 0, 1, 1, 0)};
      mode = 2'b10; dir = 1'b1; en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         load     = (i == 0) || (i == 6);
         load_val = (i == 0) ? 4'd7 : 4'd2;
         sb.push_back(exp_tab[i]);
         tick();
         e = sb.pop_front(); got = sample(); checks++;
         if (got !== e) begin errors++; $display("FAIL oneshot step %0d: got %b required %b", i, got, e); end
      end
      load = 1'b0;
   endtask

   task automatic test_prescaler();
      obs_t e, got;
      int   en_pat[9]  = '{1, 1, 0, 1, 1, 1, 1, 1, 1};
      int   cnt_exp[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
      mode = 2'b00; dir = 1'b1; presc = 4'd3; cmp_val = 4'd1; en = 1'b0; clr = 1'b1;
      sb.push_back(mk(0, 0, 1, 1, 0));
      tick();
      e = sb.pop_front(); got = sample();
      // ovf was set by the one-shot run; clr must drop it
      e.ovf = 1'b0; checks++;
      if (got !== e) begin errors++; $display("FAIL presc_clr: got %b required %b", got, e); end
      clr = 1'b0;
      for (int i = 0; i < 9; i++) begin
         en = en_pat[i][0];
         sb.push_back(mk(cnt_exp[i], 0, 0, 1, cnt_exp[i] == 1));
         tick();
         e = sb.pop_front(); got = sample(); checks++;
         if (got !== e) begin errors++; $display("FAIL presc step %0d: got %b required %b", i, got, e); end
      end
      en = 1'b1;
      sb.push_back(mk(2, 0, 0, 1, 0));
      tick();
      e = sb.pop_front(); got = sample(); checks++;
      if (got !== e) begin errors++; $display("FAIL presc_partial: got %b required %b", got, e); end
      presc = 4'd0;
      sb.push_back(mk(3, 0, 0, 1, 0));
      tick();
      e = sb.pop_front(); got = sample(); checks++;
      if (got !== e) begin errors++; $display("FAIL presc_reduce: got %b required %b", got, e); end
      cmp_val = 4'd15;
   endtask

   task automatic test_load_clip();
      obs_t e, got;
      en = 1'b0; dir = 1'b1; mode = 2'b00; presc = '0;
      load = 1'b1; load_val = 4'd15;
      sb.push_back(mk(9, 0, 0, 1, 0));
      tick();
      e = sb.pop_front(); got = sample(); checks++;
      if (got !== e) begin errors++; $display("FAIL load_clip: got %b required %b", got, e); end
      en = 1'b1; load_val = 4'd4;
      sb.push_back(mk(4, 0, 0, 1, 0));
      tick();
      e = sb.pop_front(); got = sample(); checks++;
      if (got !== e) begin errors++; $display("FAIL load_over_boundary: got %b required %b", got, e); end
      clr = 1'b1; load_val = 4'd6;
      sb.push_back(mk(0, 0, 0, 1, 0));
      tick();
      e = sb.pop_front(); got = sample(); checks++;
      if (got !== e) begin errors++; $display("FAIL clr_beats_load: got %b required %b", got, e); end
      clr = 1'b0; load = 1'b0;
   endtask

   task automatic test_async_reset();
      obs_t e, got;
      en = 1'b1; dir = 1'b1; mode = 2'b00; presc = '0;
      for (int i = 1; i <= 5; i++) begin
         sb.push_back(mk(i, 0, 0, 1, 0));
         tick();
         e = sb.pop_front(); got = sample(); checks++;
         if (got !== e) begin errors++; $display("FAIL async_pre step %0d: got %b required %b", i, got, e); end
      end
      #2;
      reset = 1'b1;
      sb.push_back(mk(0, 0, 0, 1, 0));
      #1;
      e = sb.pop_front(); got = sample(); checks++;
      if (got !== e) begin errors++; $display("FAIL async_reset_now: got %b required %b", got, e); end
      sb.push_back(mk(0, 0, 0, 1, 0));
      tick();
      e = sb.pop_front(); got = sample(); checks++;
      if (got !== e) begin errors++; $display("FAIL async_reset_held: got %b required %b", got, e); end
      reset = 1'b0;
      sb.push_back(mk(1, 0, 0, 1, 0));
      tick();
      e = sb.pop_front(); got = sample(); checks++;
      if (got !== e) begin errors++; $display("FAIL async_release: got %b required %b", got, e); end
   endtask

   initial begin
      test_reset();
      test_wrap_up();
      test_wrap_down();
      test_saturate();
      test_oneshot();
      test_prescaler();
      test_load_clip();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
